// File: rtl/k423_if_prefetch_if.sv
`default_nettype none
// ------------------------------------------------------------------
// k423_if_prefetch_if : instruction-memory and IF->ID handshake bus
// Rev 1.0
// ------------------------------------------------------------------
interface k423_if_prefetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int FETCH_N = 2
);
  logic                      if_mem_req_vld_o;
  logic                      if_mem_req_wen_o;
  logic [ADDR_W-1:0]         if_mem_req_addr_o;
  logic [INST_W-1:0]         if_mem_req_wdata_o;
  logic                      if_mem_req_rdy_i;
  logic                      if_mem_rsp_vld_i;
  logic [FETCH_N*INST_W-1:0] if_mem_rsp_rdata_i;
  logic                      if_stage_vld_o;
  logic                      id_stage_rdy_i;
  logic [ADDR_W-1:0]         if_pc_o;
  logic [INST_W-1:0]         if_inst_o;

  modport master (
    output if_mem_req_vld_o, if_mem_req_wen_o, if_mem_req_addr_o, if_mem_req_wdata_o,
    input  if_mem_req_rdy_i, if_mem_rsp_vld_i, if_mem_rsp_rdata_i,
    output if_stage_vld_o, if_pc_o, if_inst_o,
    input  id_stage_rdy_i
  );

  modport slave (
    input  if_mem_req_vld_o, if_mem_req_wen_o, if_mem_req_addr_o, if_mem_req_wdata_o,
    output if_mem_req_rdy_i, if_mem_rsp_vld_i, if_mem_rsp_rdata_i,
    input  if_stage_vld_o, if_pc_o, if_inst_o,
    output id_stage_rdy_i
  );
endinterface
`default_nettype wire

// File: rtl/k423_if_prefetch.sv
`default_nettype none
// ------------------------------------------------------------------
// k423_if_prefetch : multi-outstanding block fetch with instruction buffer
// Rev 1.0
// ------------------------------------------------------------------
module k423_if_prefetch #(
  parameter int              ADDR_W    = 32,
  parameter int              INST_W    = 32,
  parameter int              FETCH_N   = 2,
  parameter int              OST_DEPTH = 2,
  parameter int              BUF_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RST_PC  = 32'h8000_0000
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  input  wire logic              pcu_stall_pc_i,
  input  wire logic              wb_excp_br_tkn_i,
  input  wire logic [ADDR_W-1:0] wb_excp_br_pc_i,
  input  wire logic              wb_bju_br_tkn_i,
  input  wire logic [ADDR_W-1:0] wb_bju_br_pc_i,
  k423_if_prefetch_if.master     bus
);

  localparam int LOG_FN    = $clog2(FETCH_N);
  localparam int OFF_W     = (LOG_FN > 0) ? LOG_FN : 1;
  localparam int BLK_B     = LOG_FN + 2;
  localparam int OPW       = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
  localparam int BPW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCW       = $clog2(OST_DEPTH + 1);
  localparam int BCW       = $clog2(BUF_DEPTH + 1);
  localparam int OFS_SLOTS = 2 ** OPW;
  localparam int BUF_SLOTS = 2 ** BPW;
  localparam logic [ADDR_W-1:0] BLK_MASK  = {ADDR_W{1'b1}} << BLK_B;
  localparam logic [ADDR_W-1:0] BLK_BYTES = ADDR_W'(FETCH_N * 4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_blk_q, rsp_blk_d;
  logic [OCW-1:0]    ost_cnt_q, ost_cnt_d;
  logic [OCW-1:0]    kill_cnt_q, kill_cnt_d;
  logic [OPW-1:0]    ofs_wp_q, ofs_wp_d;
  logic [OPW-1:0]    ofs_rp_q, ofs_rp_d;
  logic [BPW-1:0]    buf_wp_q, buf_wp_d;
  logic [BPW-1:0]    buf_rp_q, buf_rp_d;
  logic [BCW-1:0]    buf_cnt_q, buf_cnt_d;

  logic [OFF_W-1:0]  ofs_mem_q  [OFS_SLOTS];
  logic [ADDR_W-1:0] buf_pc_q   [BUF_SLOTS];
  logic [INST_W-1:0] buf_inst_q [BUF_SLOTS];

  logic              w_redirect;
  logic [ADDR_W-1:0] w_tgt;
  logic [OFF_W-1:0]  w_req_off;
  logic [BCW-1:0]    w_free;
  logic [31:0]       w_need;
  logic              w_credit;
  logic              w_req_vld;
  logic              w_req_fire;
  logic              w_rsp;
  logic              w_rsp_kill;
  logic              w_rsp_live;
  logic [OFF_W-1:0]  w_rsp_off;
  logic [BCW-1:0]    w_push_n;
  logic              w_vld;
  logic              w_pop;

  assign w_redirect = wb_excp_br_tkn_i | wb_bju_br_tkn_i;
  assign w_tgt      = wb_excp_br_tkn_i ? wb_excp_br_pc_i : wb_bju_br_pc_i;

  generate
    if (LOG_FN > 0) begin : g_off_bits
      assign w_req_off = pc_q[BLK_B-1:2];
    end else begin : g_off_none
      assign w_req_off = '0;
    end
  endgenerate

  // Every in-flight block reserves FETCH_N slots, so a response always fits.
  assign w_free     = BCW'(BUF_DEPTH) - buf_cnt_q;
  assign w_need     = 32'(FETCH_N) * (32'(ost_cnt_q) + 32'd1);
  assign w_credit   = 32'(w_free) >= w_need;
  assign w_req_vld  = ~rst_i & ~pcu_stall_pc_i & ~w_redirect &
                      (ost_cnt_q < OCW'(OST_DEPTH)) & w_credit;
  assign w_req_fire = w_req_vld & bus.if_mem_req_rdy_i;

  assign w_rsp      = bus.if_mem_rsp_vld_i;
  assign w_rsp_kill = w_rsp & ((kill_cnt_q != '0) | w_redirect);
  assign w_rsp_live = w_rsp & ~w_rsp_kill;
  assign w_rsp_off  = ofs_mem_q[ofs_rp_q];
  assign w_push_n   = w_rsp_live ? (BCW'(FETCH_N) - BCW'(w_rsp_off)) : '0;

  assign w_vld      = (buf_cnt_q != '0);
  assign w_pop      = w_vld & bus.id_stage_rdy_i & ~w_redirect;

  always_comb begin
    pc_d       = pc_q;
    rsp_blk_d  = rsp_blk_q;
    ost_cnt_d  = ost_cnt_q;
    kill_cnt_d = kill_cnt_q;
    ofs_wp_d   = ofs_wp_q + OPW'(w_req_fire);
    ofs_rp_d   = ofs_rp_q + OPW'(w_rsp);
    buf_wp_d   = buf_wp_q;
    buf_rp_d   = buf_rp_q;
    buf_cnt_d  = buf_cnt_q;
    if (w_redirect) begin
      // All requests still outstanding after this cycle belong to the old path.
      pc_d       = w_tgt;
      rsp_blk_d  = w_tgt & BLK_MASK;
      ost_cnt_d  = ost_cnt_q - OCW'(w_rsp);
      kill_cnt_d = ost_cnt_q - OCW'(w_rsp);
      buf_wp_d   = '0;
      buf_rp_d   = '0;
      buf_cnt_d  = '0;
    end else begin
      if (w_req_fire) begin
        pc_d = (pc_q & BLK_MASK) + BLK_BYTES;
      end
      ost_cnt_d = ost_cnt_q + OCW'(w_req_fire) - OCW'(w_rsp);
      if (w_rsp_kill) begin
        kill_cnt_d = kill_cnt_q - OCW'(1);
      end
      if (w_rsp_live) begin
        rsp_blk_d = rsp_blk_q + BLK_BYTES;
      end
      buf_wp_d  = buf_wp_q + BPW'(w_push_n);
      buf_rp_d  = buf_rp_q + BPW'(w_pop);
      buf_cnt_d = buf_cnt_q + w_push_n - BCW'(w_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RST_PC;
      rsp_blk_q  <= RST_PC & BLK_MASK;
      ost_cnt_q  <= '0;
      kill_cnt_q <= '0;
      ofs_wp_q   <= '0;
      ofs_rp_q   <= '0;
      buf_wp_q   <= '0;
      buf_rp_q   <= '0;
      buf_cnt_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_blk_q  <= rsp_blk_d;
      ost_cnt_q  <= ost_cnt_d;
      kill_cnt_q <= kill_cnt_d;
      ofs_wp_q   <= ofs_wp_d;
      ofs_rp_q   <= ofs_rp_d;
      buf_wp_q   <= buf_wp_d;
      buf_rp_q   <= buf_rp_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  // Lanes below the entry offset (misaligned redirect target) are never written.
  always_ff @(posedge clk_i) begin
    if (w_req_fire) begin
      ofs_mem_q[ofs_wp_q] <= w_req_off;
    end
    for (int l = 0; l < FETCH_N; l++) begin
      if (w_rsp_live && (l >= int'(w_rsp_off))) begin
        buf_pc_q[buf_wp_q + BPW'(l) - BPW'(w_rsp_off)]   <= rsp_blk_q + ADDR_W'(4 * l);
        buf_inst_q[buf_wp_q + BPW'(l) - BPW'(w_rsp_off)] <= bus.if_mem_rsp_rdata_i[l*INST_W +: INST_W];
      end
    end
  end

  assign bus.if_mem_req_vld_o   = w_req_vld;
  assign bus.if_mem_req_wen_o   = 1'b0;
  assign bus.if_mem_req_addr_o  = pc_q & BLK_MASK;
  assign bus.if_mem_req_wdata_o = '0;
  assign bus.if_stage_vld_o     = w_vld;
  assign bus.if_pc_o            = w_vld ? buf_pc_q[buf_rp_q]   : '0;
  assign bus.if_inst_o          = w_vld ? buf_inst_q[buf_rp_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_k423_if_prefetch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_k423_if_prefetch : directed bench with in-order memory model
// Rev 1.0
// ------------------------------------------------------------------
module tb_k423_if_prefetch;
  localparam int ADDR_W = 32, INST_W = 32, FETCH_N = 2, OST_DEPTH = 2, BUF_DEPTH = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, excp_tkn, bju_tkn;
  logic [31:0] excp_pc, bju_pc;

  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, lat = 1, ost_tb = 0, max_ost = 0, rc = 0;
  bit   found;
  ent_t mq[$], reqq[$], idq[$];

  k423_if_prefetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .FETCH_N(FETCH_N)) bus ();

  k423_if_prefetch #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .FETCH_N(FETCH_N),
    .OST_DEPTH(OST_DEPTH), .BUF_DEPTH(BUF_DEPTH), .RST_PC(32'h8000_0000)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pcu_stall_pc_i(stall),
    .wb_excp_br_tkn_i(excp_tkn), .wb_excp_br_pc_i(excp_pc),
    .wb_bju_br_tkn_i(bju_tkn), .wb_bju_br_pc_i(bju_pc),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkinst(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] req_a(input int k);
    return (k < reqq.size()) ? reqq[k].a : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] req_c(input int k);
    return (k < reqq.size()) ? 32'(reqq[k].c) : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] id_pc(input int k);
    return (k < idq.size()) ? idq[k].a : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] id_inst(input int k);
    return (k < idq.size()) ? idq[k].d : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] id_c(input int k);
    return (k < idq.size()) ? 32'(idq[k].c) : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    reqq.delete();
    idq.delete();
    max_ost = ost_tb;
  endtask

  // Memory model (in-order, fixed latency) plus request/ID monitors.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        mq.delete();
        ost_tb = 0;
        bus.if_mem_rsp_vld_i = 1'b0;
      end else if (mq.size() > 0 && mq[0].c <= cyc) begin
        bus.if_mem_rsp_vld_i   = 1'b1;
        bus.if_mem_rsp_rdata_i = {mkinst(mq[0].a + 32'd4), mkinst(mq[0].a)};
        void'(mq.pop_front());
        ost_tb--;
      end else begin
        bus.if_mem_rsp_vld_i = 1'b0;
      end
      @(negedge clk);
      if (!rst && bus.if_mem_req_vld_o && bus.if_mem_req_rdy_i) begin
        mq.push_back('{bus.if_mem_req_addr_o, 32'h0, cyc + lat});
        reqq.push_back('{bus.if_mem_req_addr_o, 32'h0, cyc});
        ost_tb++;
        if (ost_tb > max_ost) max_ost = ost_tb;
      end
      if (!rst && bus.if_stage_vld_o && bus.id_stage_rdy_i && !excp_tkn && !bju_tkn)
        idq.push_back('{bus.if_pc_o, bus.if_inst_o, cyc});
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; excp_tkn = 1'b0; bju_tkn = 1'b0;
    excp_pc = '0; bju_pc = '0;
    bus.if_mem_req_rdy_i = 1'b1; bus.id_stage_rdy_i = 1'b1;
    bus.if_mem_rsp_vld_i = 1'b0; bus.if_mem_rsp_rdata_i = '0;

    // Reset values
    tick(2); neg();
    chk("rst_req_vld",   32'(bus.if_mem_req_vld_o),   32'd0);
    chk("rst_stage_vld", 32'(bus.if_stage_vld_o),     32'd0);
    chk("rst_pc",        bus.if_pc_o,                 32'd0);
    chk("rst_inst",      bus.if_inst_o,               32'd0);
    chk("rst_wen",       32'(bus.if_mem_req_wen_o),   32'd0);
    chk("rst_wdata",     bus.if_mem_req_wdata_o,      32'd0);

    // Reset release, 1-cycle memory, ID ready
    tick(1); rst = 1'b0; clr();
    tick(12);
    chk("p1_req0",    req_a(0), 32'h8000_0000);
    chk("p1_req1",    req_a(1), 32'h8000_0008);
    for (int k = 0; k < 4; k++)
      chk($sformatf("p1_id_pc%0d", k), id_pc(k), 32'h8000_0000 + 32'(4 * k));
    chk("p1_inst0",   id_inst(0), mkinst(32'h8000_0000));
    chk("p1_inst3",   id_inst(3), mkinst(32'h8000_000C));
    chk("p1_consec",  id_c(3) - id_c(0), 32'd3);
    chk("p1_latency", id_c(0) - req_c(0), 32'd2);

    // ID held off: buffer fills with exactly BUF_DEPTH/FETCH_N blocks
    bus.id_stage_rdy_i = 1'b0; bju_tkn = 1'b1; bju_pc = 32'h8000_1000; clr();
    tick(1); bju_tkn = 1'b0;
    tick(20); neg();
    chk("p2_nreq",      32'(reqq.size()), 32'd4);
    chk("p2_req3",      req_a(3), 32'h8000_1018);
    chk("p2_req_vld",   32'(bus.if_mem_req_vld_o), 32'd0);
    chk("p2_stage_vld", 32'(bus.if_stage_vld_o), 32'd1);
    chk("p2_head_pc",   bus.if_pc_o, 32'h8000_1000);
    chk("p2_head_inst", bus.if_inst_o, mkinst(32'h8000_1000));
    tick(1); bus.id_stage_rdy_i = 1'b1;
    tick(12);
    for (int k = 0; k < 8; k++)
      chk($sformatf("p2_id_pc%0d", k), id_pc(k), 32'h8000_1000 + 32'(4 * k));

    // Stall blocks requests in the same cycle
    stall = 1'b1; neg();
    chk("stall_req_vld", 32'(bus.if_mem_req_vld_o), 32'd0);

    // Latency 3: two outstanding, third only after the first response
    tick(6);
    stall = 1'b0; lat = 3; bju_tkn = 1'b1; bju_pc = 32'h8000_2000; clr();
    tick(1); bju_tkn = 1'b0;
    tick(10);
    chk("p3_req0",     req_a(0), 32'h8000_2000);
    chk("p3_gap1",     req_c(1) - req_c(0), 32'd1);
    chk("p3_gap2",     req_c(2) - req_c(0), 32'd4);
    chk("p3_req2",     req_a(2), 32'h8000_2010);
    chk("p3_max_ost",  32'(max_ost), 32'd2);
    chk("p3_id_pc0",   id_pc(0), 32'h8000_2000);
    chk("p3_id_lat",   id_c(0) - req_c(0), 32'd4);

    // Branch to misaligned target with two stale requests in flight
    stall = 1'b1; tick(8);
    stall = 1'b0; bju_tkn = 1'b1; bju_pc = 32'h8000_3000;
    tick(1); bju_tkn = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (ost_tb == 2 && !bus.if_mem_rsp_vld_i) found = 1'b1;
    end
    chk("p4_wait", 32'(found), 32'd1);
    bju_tkn = 1'b1; bju_pc = 32'h8000_0104; rc = cyc; clr();
    tick(1); bju_tkn = 1'b0;
    tick(12);
    chk("p4_req0",    req_a(0), 32'h8000_0100);
    chk("p4_req0_c",  req_c(0), 32'(rc + 2));
    chk("p4_id_pc0",  id_pc(0), 32'h8000_0104);
    chk("p4_id_inst", id_inst(0), mkinst(32'h8000_0104));
    chk("p4_id_pc1",  id_pc(1), 32'h8000_0108);

    // Exception and branch together with a response in the same cycle
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (bus.if_mem_rsp_vld_i && ost_tb == 1) found = 1'b1;
    end
    chk("p5_wait", 32'(found), 32'd1);
    excp_tkn = 1'b1; excp_pc = 32'h8000_0200;
    bju_tkn = 1'b1; bju_pc = 32'h8000_0300; rc = cyc; clr();
    tick(1); excp_tkn = 1'b0; bju_tkn = 1'b0;
    tick(12);
    chk("p5_req0",   req_a(0), 32'h8000_0200);
    chk("p5_req0_c", req_c(0), 32'(rc + 1));
    chk("p5_id_pc0", id_pc(0), 32'h8000_0200);
    chk("p5_id_pc1", id_pc(1), 32'h8000_0204);

    // Reset mid-burst
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (ost_tb > 0) found = 1'b1;
    end
    chk("p6_wait", 32'(found), 32'd1);
    rst = 1'b1; neg();
    chk("p6_req_vld",   32'(bus.if_mem_req_vld_o), 32'd0);
    chk("p6_stage_vld", 32'(bus.if_stage_vld_o),   32'd0);
    chk("p6_pc",        bus.if_pc_o,               32'd0);
    chk("p6_inst",      bus.if_inst_o,             32'd0);
    tick(2); rst = 1'b0; lat = 1; rc = cyc; clr();
    tick(10);
    chk("p6_req0",   req_a(0), 32'h8000_0000);
    chk("p6_req0_c", req_c(0), 32'(rc));
    chk("p6_id_pc0", id_pc(0), 32'h8000_0000);
    chk("p6_id_c0",  id_c(0),  32'(rc + 2));
    chk("p6_id_pc1", id_pc(1), 32'h8000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/k423_if_prefetch.md
# k423_if_prefetch

Parametrised instruction-fetch stage with multiple outstanding memory requests, a FETCH_N-wide fetch block and an instruction buffer. It generates sequential fetch PCs and keeps up to OST_DEPTH requests in flight under buffer-credit control. Responses are unpacked into per-instruction entries and presented to ID one per cycle. Redirects from WB (exception or branch) flush the buffer and squash stale in-flight responses. Sits between the PC control unit/WB redirect paths and the ID stage, on the instruction memory request/response bus.

## Interface
- ADDR_W, 32, fetch address width.
- INST_W, 32, instruction width (4 bytes).
- FETCH_N, 2, instructions per fetch block (power of two, 1..4).
- OST_DEPTH, 2, maximum outstanding memory requests (power of two, 1..4).
- BUF_DEPTH, 8, instruction buffer entries (power of two, ≥ FETCH_N*OST_DEPTH).
- RST_PC, 32'h8000_0000, reset fetch PC.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- pcu_stall_pc_i  in  1  block new requests; responses still accepted.
- wb_excp_br_tkn_i / wb_excp_br_pc_i  in  1 / ADDR_W  exception redirect (highest priority).
- wb_bju_br_tkn_i / wb_bju_br_pc_i  in  1 / ADDR_W  branch redirect.
- if_mem_req_vld_o  out  1  request valid.
- if_mem_req_wen_o  out  1  constant 0.
- if_mem_req_addr_o  out  ADDR_W  block-aligned fetch address.
- if_mem_req_wdata_o  out  INST_W  constant 0.
- if_mem_req_rdy_i  in  1  request accepted when vld&rdy.
- if_mem_rsp_vld_i  in  1  in-order response valid.
- if_mem_rsp_rdata_i  in  FETCH_N*INST_W  block data, lane 0 in LSBs.
- if_stage_vld_o  out  1  instruction valid to ID.
- id_stage_rdy_i  in  1  ID accepts.
- if_pc_o  out  ADDR_W  PC of presented instruction.
- if_inst_o  out  INST_W  presented instruction.

## Operation
- Registers: pc, ost_cnt (0..OST_DEPTH), kill_cnt (0..OST_DEPTH), lane-offset FIFO (OST_DEPTH × log2(FETCH_N)), instruction buffer (pc+inst, BUF_DEPTH).
- Request: if_mem_req_vld_o = ~stall & ~redirect & ost_cnt<OST_DEPTH & free_slots ≥ FETCH_N*(ost_cnt+1). Address = pc with low log2(FETCH_N)+2 bits cleared. Offset field = pc[log2(FETCH_N)+1:2].
- On handshake: push offset into offset FIFO, ost_cnt+1, pc ← aligned pc + FETCH_N*4 (wraps modulo 2^ADDR_W).
- Response with kill_cnt>0: dropped, kill_cnt−1, ost_cnt−1, offset FIFO pop.
- Response with kill_cnt=0: pop offset; push lanes offset..FETCH_N−1 into buffer in lane order, pc = block address + 4*lane; ost_cnt−1.
- Output: head of buffer; if_stage_vld_o = ~empty; pop on vld&rdy.
- Redirect (excp or bju, excp target wins): pc ← target next cycle; buffer emptied; pop ignored; no request that cycle; kill_cnt ← ost_cnt − rsp_vld (a response in the redirect cycle is itself dropped); offset FIFO keeps entries for killed responses.
- Redirect while kill_cnt>0: same formula (all still-outstanding become stale).
- Misaligned target: first block fetched from aligned address, leading lanes discarded via offset.

## Timing
- Reset: pc=RST_PC, ost_cnt=0, kill_cnt=0, buffer empty; if_stage_vld_o=0, if_pc_o=0, if_inst_o=0, if_mem_req_vld_o=0 while rst_i high, wen/wdata 0 always.
- Memory response latency ≥1 cycle after request handshake; responses strictly in order.
- Response data visible at if_stage_vld_o the cycle after rsp_vld (no bypass).
- Simultaneous push and pop: both occur; count adjusts by pushed−popped.
- Credit rule guarantees no buffer overflow; a response never stalls.
- First request after redirect: cycle after redirect, if credits allow (buffer always empty then).
- Stall: req_vld low same cycle; pc held.

## Test plan
- Reset release, FETCH_N=2, 1-cycle memory, ID always ready -> requests 0x8000_0000, 0x8000_0008; ID sees PCs 0x8000_0000, _0004, _0008, _000C in consecutive cycles once filled.
- ID rdy held low -> at most BUF_DEPTH/FETCH_N blocks fetched (8 instructions), req_vld drops, no entry lost; resume gives in-order PCs.
- Memory latency 3, OST_DEPTH=2 -> exactly 2 requests outstanding, third issued only after first response.
- Branch redirect to 0x8000_0104 with 2 outstanding -> both stale responses dropped, next ID PC 0x8000_0104 (lane 0 of block 0x8000_0100 discarded), then 0x8000_0108.
- Excp and bju redirect same cycle (0x8000_0200 / 0x8000_0300), response arriving same cycle -> target 0x8000_0200, that response dropped, kill_cnt = ost_cnt−1.
- Assert rst_i mid-burst with outstanding requests -> all outputs reset values immediately, refetch from RST_PC.
